clut_banked: RTL and testbench

Multi-bank colour lookup table for the display pipeline. It maps a per-pixel colour index to an output colour through one of `BANKS` register palettes. Palettes are loaded at runtime over a valid/ready stream. The active bank is double-buffered: a bank switch only takes effect at a frame boundary, so palette swaps never tear mid-frame. It sits between the pixel index generator and the video output registers.

---
 rtl/clut_pkg.sv | 16 +
 rtl/clut_load_fsm.sv | 83 ++++++++
 rtl/clut_banked.sv | 153 +++++++++++++++
 tb/tb_clut_banked.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clut_pkg.sv
// rtl/clut_pkg.sv - shared types, constants and bank-width helper for the banked CLUT
package clut_pkg;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_LOAD = 1'b1
  } ld_state_e;

  localparam logic [63:0] CLUT_RESET_COLR = 64'd0;

  // A single bank still needs a 1-bit select so ports never collapse to zero width.
  function automatic int clut_bankw(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/clut_load_fsm.sv
// rtl/clut_load_fsm.sv - palette load handshake: bank/pointer capture, beat acceptance, done pulse
module clut_load_fsm
  import clut_pkg::*;
#(
  parameter int CIDXW = 4,
  parameter int BANKS = 2,
  parameter int BANKW = clut_bankw(BANKS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ld_start,
  input  logic [BANKW-1:0] i_ld_bank,
  input  logic [CIDXW-1:0] i_ld_base,
  input  logic             i_ld_valid,
  input  logic             i_ld_last,
  output logic             o_ld_ready,
  output logic             o_ld_done,
  output logic             o_we,
  output logic [BANKW-1:0] o_wbank,
  output logic [CIDXW-1:0] o_waddr
);

  localparam logic [BANKW:0] BANK_LIM = BANKS[BANKW:0];

  ld_state_e        r_state;
  ld_state_e        w_state_nxt;
  logic [CIDXW-1:0] r_ptr;
  logic [BANKW-1:0] r_bank;
  logic             r_done;
  logic             w_start_ok;
  logic             w_accept;

  assign w_start_ok = i_ld_start && ({1'b0, i_ld_bank} < BANK_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LD_IDLE: if (w_start_ok) w_state_nxt = LD_LOAD;
      LD_LOAD: if (w_accept && i_ld_last) w_state_nxt = LD_IDLE;
      default: w_state_nxt = LD_IDLE;
    endcase
  end

  always_comb begin
    o_ld_ready = 1'b0;
    w_accept   = 1'b0;
    if (r_state == LD_LOAD) begin
      o_ld_ready = 1'b1;
      w_accept   = i_ld_valid;
    end
  end

  // Pointer wraps naturally at 2**CIDXW entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_bank <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_accept && i_ld_last;
      if ((r_state == LD_IDLE) && w_start_ok) begin
        r_bank <= i_ld_bank;
        r_ptr  <= i_ld_base;
      end else if (w_accept) begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  assign o_we      = w_accept;
  assign o_wbank   = r_bank;
  assign o_waddr   = r_ptr;
  assign o_ld_done = r_done;

endmodule

// File: rtl/clut_banked.sv
// rtl/clut_banked.sv - multi-bank colour lookup table with frame-synchronous bank switch (option: CLUT_BLANK_EN)
module clut_banked
  import clut_pkg::*;
#(
  parameter int COLRW = 12,
  parameter int CIDXW = 4,
  parameter int BANKS = 2,
  parameter int BANKW = clut_bankw(BANKS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic             pix_de,
  input  logic [CIDXW-1:0] pix_idx,
  output logic             colr_valid,
  output logic [COLRW-1:0] colr_out,
  input  logic             sel_req,
  input  logic [BANKW-1:0] sel_bank,
  output logic [BANKW-1:0] act_bank,
  input  logic             ld_start,
  input  logic [BANKW-1:0] ld_bank,
  input  logic [CIDXW-1:0] ld_base,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [COLRW-1:0] ld_data,
  input  logic             ld_last,
  output logic             ld_done
);

  localparam int              DEPTH    = 1 << CIDXW;
  localparam logic [BANKW:0]  BANK_LIM = BANKS[BANKW:0];
  localparam logic [COLRW-1:0] RST_COLR = CLUT_RESET_COLR[COLRW-1:0];

  logic [COLRW-1:0] r_pal [BANKS][DEPTH];
  logic             r_s1_valid;
  logic [CIDXW-1:0] r_s1_idx;
  logic [BANKW-1:0] r_s1_bank;
  logic             r_colr_valid;
  logic [COLRW-1:0] r_colr_out;
  logic             r_pend;
  logic [BANKW-1:0] r_pend_bank;
  logic [BANKW-1:0] r_act_bank;
  logic             w_sel_ok;
  logic             w_we;
  logic [BANKW-1:0] w_wbank;
  logic [CIDXW-1:0] w_waddr;
  logic [COLRW-1:0] w_rd;

  clut_load_fsm #(
    .CIDXW (CIDXW),
    .BANKS (BANKS),
    .BANKW (BANKW)
  ) u_load_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ld_start (ld_start),
    .i_ld_bank  (ld_bank),
    .i_ld_base  (ld_base),
    .i_ld_valid (ld_valid),
    .i_ld_last  (ld_last),
    .o_ld_ready (ld_ready),
    .o_ld_done  (ld_done),
    .o_we       (w_we),
    .o_wbank    (w_wbank),
    .o_waddr    (w_waddr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int e = 0; e < DEPTH; e++) begin
          r_pal[b][e] <= RST_COLR;
        end
      end
    end else if (w_we) begin
      r_pal[w_wbank][w_waddr] <= ld_data;
    end
  end

  // A request arriving with frame_start wins over any older pending one.
  assign w_sel_ok = sel_req && ({1'b0, sel_bank} < BANK_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= 1'b0;
      r_pend_bank <= '0;
      r_act_bank  <= '0;
    end else if (frame_start) begin
      r_pend <= 1'b0;
      if (w_sel_ok) begin
        r_act_bank <= sel_bank;
      end else if (r_pend) begin
        r_act_bank <= r_pend_bank;
      end
    end else if (w_sel_ok) begin
      r_pend      <= 1'b1;
      r_pend_bank <= sel_bank;
    end
  end

  assign w_rd = r_pal[r_s1_bank][r_s1_idx];

`ifdef CLUT_BLANK_EN
  logic r_s1_de;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_de <= 1'b0;
    end else begin
      r_s1_de <= pix_de;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_colr_out <= RST_COLR;
    end else begin
      r_colr_out <= r_s1_de ? w_rd : RST_COLR;
    end
  end
`else
  logic w_unused_de;
  assign w_unused_de = pix_de;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_colr_out <= RST_COLR;
    end else begin
      r_colr_out <= w_rd;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_idx     <= '0;
      r_s1_bank    <= '0;
      r_colr_valid <= 1'b0;
    end else begin
      r_s1_valid   <= pix_valid;
      r_s1_idx     <= pix_idx;
      r_s1_bank    <= r_act_bank;
      r_colr_valid <= r_s1_valid;
    end
  end

  assign colr_valid = r_colr_valid;
  assign colr_out   = r_colr_out;
  assign act_bank   = r_act_bank;

endmodule

// File: tb/tb_clut_banked.sv
// tb/tb_clut_banked.sv - randomized self-checking bench for clut_banked against a palette/bank reference model
module tb_clut_banked;

  localparam int COLRW = 12;
  localparam int CIDXW = 4;
  localparam int BANKS = 3;
  localparam int BANKW = 2;
`ifdef CLUT_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             frame_start = 1'b0;
  logic             pix_valid = 1'b0;
  logic             pix_de = 1'b0;
  logic [CIDXW-1:0] pix_idx = '0;
  logic             colr_valid;
  logic [COLRW-1:0] colr_out;
  logic             sel_req = 1'b0;
  logic [BANKW-1:0] sel_bank = '0;
  logic [BANKW-1:0] act_bank;
  logic             ld_start = 1'b0;
  logic [BANKW-1:0] ld_bank = '0;
  logic [CIDXW-1:0] ld_base = '0;
  logic             ld_valid = 1'b0;
  logic             ld_ready;
  logic [COLRW-1:0] ld_data = '0;
  logic             ld_last = 1'b0;
  logic             ld_done;

  always #5 clk = ~clk;

  clut_banked #(
    .COLRW (COLRW),
    .CIDXW (CIDXW),
    .BANKS (BANKS),
    .BANKW (BANKW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_de      (pix_de),
    .pix_idx     (pix_idx),
    .colr_valid  (colr_valid),
    .colr_out    (colr_out),
    .sel_req     (sel_req),
    .sel_bank    (sel_bank),
    .act_bank    (act_bank),
    .ld_start    (ld_start),
    .ld_bank     (ld_bank),
    .ld_base     (ld_base),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_done     (ld_done)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: palette contents, displayed/pending bank, load progress, staged pixel.
  logic [COLRW-1:0] mpal [BANKS][16];
  logic [1:0]       mact, mpend_b, mbank, s1b;
  logic [3:0]       mptr, s1i;
  bit               mpend, mload, mdone, s1v, s1de, e_cv;
  logic [COLRW-1:0] e_co;

  task automatic model_reset();
    for (int b = 0; b < BANKS; b++)
      for (int e = 0; e < 16; e++) mpal[b][e] = '0;
    mact = 0; mpend_b = 0; mpend = 0; mload = 0; mbank = 0; mptr = 0; mdone = 0;
    s1v = 0; s1de = 0; s1i = 0; s1b = 0; e_cv = 0; e_co = '0;
  endtask

  task automatic idle_inputs();
    frame_start = 0; pix_valid = 0; pix_de = 0; pix_idx = 0; sel_req = 0; sel_bank = 0;
    ld_start = 0; ld_bank = 0; ld_base = 0; ld_valid = 0; ld_data = 0; ld_last = 0;
  endtask

  // Advance one clock: the model consumes the inputs now driven, then the DUT edge happens.
  task automatic cycle();
    bit n_cv, acc, sel_ok;
    logic [COLRW-1:0] n_co;
    n_cv = s1v;
    n_co = (BLANK && !s1de) ? 12'h000 : mpal[s1b][s1i];
    s1v = pix_valid; s1de = pix_de; s1i = pix_idx; s1b = mact;
    acc = mload && ld_valid;
    if (acc) begin
      mpal[mbank][mptr] = ld_data;
      mptr = (mptr + 4'd1) % 16;
    end
    mdone = acc && ld_last;
    if (mdone) mload = 0;
    else if (!mload && ld_start && ld_bank < BANKS) begin
      mload = 1; mbank = ld_bank; mptr = ld_base;
    end
    sel_ok = sel_req && (sel_bank < BANKS);
    if (frame_start) begin
      if (sel_ok) mact = sel_bank;
      else if (mpend) mact = mpend_b;
      mpend = 0;
    end else if (sel_ok) begin
      mpend = 1; mpend_b = sel_bank;
    end
    @(posedge clk);
    #1;
    e_cv = n_cv; e_co = n_co;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({colr_valid, colr_out, act_bank, ld_ready, ld_done} !== 17'h0) begin
      n_err++;
      $display("FAIL reset_state got=%h exp=%h", {colr_valid, colr_out, act_bank, ld_ready, ld_done}, 17'h0);
    end
    idle_inputs();
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1; pix_idx = 5; pix_de = 1;
    cycle();
    pix_valid = 0;
    cycle();
    n_vec++;
    if ({colr_valid, colr_out} !== {1'b1, 12'h000}) begin
      n_err++;
      $display("FAIL reset_lookup got=%h exp=%h", {colr_valid, colr_out}, {1'b1, 12'h000});
    end
  endtask

  task automatic test_load_wrap();
    logic [COLRW-1:0] beats [3];
    beats = '{12'hF00, 12'h0F0, 12'h00F};
    ld_start = 1; ld_bank = 1; ld_base = 14;
    cycle();
    ld_start = 0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({colr_valid, colr_out, act_bank, ld_ready, ld_done} !== {e_cv, e_co, mact, mload, mdone}) begin
        n_err++;
        $display("FAIL load_wrap beat%0d got=%h exp=%h", i, {colr_valid, colr_out, act_bank, ld_ready, ld_done}, {e_cv, e_co, mact, mload, mdone});
      end
      ld_valid = 1; ld_data = beats[i]; ld_last = (i == 2);
      cycle();
    end
    ld_valid = 0; ld_last = 0;
    n_vec++;
    if ({ld_ready, ld_done} !== 2'b01) begin
      n_err++;
      $display("FAIL load_done_pulse got=%b exp=01", {ld_ready, ld_done});
    end
    cycle();
    n_vec++;
    if ({ld_ready, ld_done} !== 2'b00) begin
      n_err++;
      $display("FAIL load_done_clear got=%b exp=00", {ld_ready, ld_done});
    end
  endtask

  task automatic test_bank_switch();
    pix_valid = 1; pix_de = 1; pix_idx = 14;
    sel_req = 1; sel_bank = 1;
    cycle();
    sel_req = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_vec++;
      if ({colr_valid, colr_out, act_bank} !== {e_cv, e_co, mact}) begin
        n_err++;
        $display("FAIL switch_pre cyc%0d got=%h exp=%h", i, {colr_valid, colr_out, act_bank}, {e_cv, e_co, mact});
      end
    end
    n_vec++;
    if (colr_out !== 12'h000) begin
      n_err++;
      $display("FAIL switch_hold got=%h exp=000", colr_out);
    end
    frame_start = 1;
    cycle();
    frame_start = 0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({colr_valid, colr_out, act_bank} !== {e_cv, e_co, mact}) begin
        n_err++;
        $display("FAIL switch_post cyc%0d got=%h exp=%h", i, {colr_valid, colr_out, act_bank}, {e_cv, e_co, mact});
      end
      cycle();
    end
    n_vec++;
    if ({act_bank, colr_out} !== {2'd1, 12'hF00}) begin
      n_err++;
      $display("FAIL switch_new got=%h exp=%h", {act_bank, colr_out}, {2'd1, 12'hF00});
    end
    pix_idx = 15; cycle(); pix_idx = 0; cycle();
    n_vec++;
    if (colr_out !== 12'h0F0) begin
      n_err++;
      $display("FAIL wrap_entry15 got=%h exp=0f0", colr_out);
    end
    cycle();
    n_vec++;
    if (colr_out !== 12'h00F) begin
      n_err++;
      $display("FAIL wrap_entry0 got=%h exp=00f", colr_out);
    end
    pix_valid = 0;
  endtask

  task automatic test_sel_rules();
    sel_req = 1; sel_bank = 0; frame_start = 1;
    cycle();
    frame_start = 0;
    n_vec++;
    if (act_bank !== 2'd0) begin
      n_err++;
      $display("FAIL sel_same_cycle got=%0d exp=0", act_bank);
    end
    sel_bank = 0; cycle();
    sel_bank = 1; cycle();
    sel_req = 0; cycle();
    n_vec++;
    if (act_bank !== 2'd0) begin
      n_err++;
      $display("FAIL sel_wait_frame got=%0d exp=0", act_bank);
    end
    frame_start = 1; cycle(); frame_start = 0;
    n_vec++;
    if (act_bank !== 2'd1) begin
      n_err++;
      $display("FAIL sel_last_wins got=%0d exp=1", act_bank);
    end
    sel_req = 1; sel_bank = 3; cycle();
    sel_req = 0; frame_start = 1; cycle(); frame_start = 0;
    n_vec++;
    if (act_bank !== 2'd1) begin
      n_err++;
      $display("FAIL sel_invalid got=%0d exp=1", act_bank);
    end
    sel_req = 1; sel_bank = 3; frame_start = 1; cycle();
    sel_req = 0; frame_start = 0;
    n_vec++;
    if (act_bank !== 2'd1) begin
      n_err++;
      $display("FAIL sel_invalid_frame got=%0d exp=1", act_bank);
    end
  endtask

  task automatic test_ld_handshake();
    int acc_cnt;
    acc_cnt = 0;
    ld_start = 1; ld_bank = 2; ld_base = 3;
    cycle();
    for (int i = 0; i < 60 && acc_cnt < 6; i++) begin
      ld_start = 1; ld_bank = 0; ld_base = 9;
      ld_valid = $urandom_range(0, 1) | (i % 4 == 3);
      ld_data = $urandom;
      ld_last = ld_valid && (acc_cnt == 5);
      if (ld_valid) acc_cnt++;
      cycle();
      n_vec++;
      if ({colr_valid, colr_out, act_bank, ld_ready, ld_done} !== {e_cv, e_co, mact, mload, mdone}) begin
        n_err++;
        $display("FAIL handshake cyc%0d got=%h exp=%h", i, {colr_valid, colr_out, act_bank, ld_ready, ld_done}, {e_cv, e_co, mact, mload, mdone});
      end
      ld_start = 0;
    end
    n_vec++;
    if (acc_cnt != 6) begin
      n_err++;
      $display("FAIL handshake_timeout got=%0d exp=6", acc_cnt);
    end
    idle_inputs();
    sel_req = 1; sel_bank = 2; frame_start = 1; cycle(); idle_inputs();
    for (int i = 0; i < 12; i++) begin
      pix_valid = 1; pix_de = 1; pix_idx = 4'(i + 2);
      cycle();
      n_vec++;
      if ({colr_valid, colr_out, act_bank, ld_ready, ld_done} !== {e_cv, e_co, mact, mload, mdone}) begin
        n_err++;
        $display("FAIL handshake_read idx%0d got=%h exp=%h", i, {colr_valid, colr_out, act_bank, ld_ready, ld_done}, {e_cv, e_co, mact, mload, mdone});
      end
    end
    idle_inputs();
  endtask

  task automatic test_blank();
    sel_req = 1; sel_bank = 1; frame_start = 1; cycle(); idle_inputs();
    pix_valid = 1; pix_de = 0; pix_idx = 14; cycle();
    pix_valid = 0; cycle();
    n_vec++;
    if ({colr_valid, colr_out} !== {1'b1, (BLANK ? 12'h000 : 12'hF00)}) begin
      n_err++;
      $display("FAIL blank got=%h exp=%h", {colr_valid, colr_out}, {1'b1, (BLANK ? 12'h000 : 12'hF00)});
    end
  endtask

  task automatic test_reset_midload();
    ld_start = 1; ld_bank = 0; ld_base = 2; cycle(); ld_start = 0;
    ld_valid = 1; ld_data = 12'hABC; cycle();
    ld_data = 12'h123; cycle();
    ld_valid = 0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({colr_valid, colr_out, act_bank, ld_ready, ld_done} !== 17'h0) begin
      n_err++;
      $display("FAIL reset_midload got=%h exp=%h", {colr_valid, colr_out, act_bank, ld_ready, ld_done}, 17'h0);
    end
    idle_inputs();
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1; pix_de = 1; pix_idx = 4'(i + 1);
      cycle();
      n_vec++;
      if ({colr_valid, colr_out, act_bank, ld_ready, ld_done} !== {e_cv, e_co, mact, mload, mdone}) begin
        n_err++;
        $display("FAIL reset_cleared cyc%0d got=%h exp=%h", i, {colr_valid, colr_out, act_bank, ld_ready, ld_done}, {e_cv, e_co, mact, mload, mdone});
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      pix_valid   = $urandom_range(0, 3) != 0;
      pix_de      = $urandom_range(0, 3) != 0;
      pix_idx     = 4'($urandom);
      frame_start = $urandom_range(0, 15) == 0;
      sel_req     = $urandom_range(0, 7) == 0;
      sel_bank    = 2'($urandom_range(0, 3));
      ld_start    = $urandom_range(0, 9) == 0;
      ld_bank     = 2'($urandom_range(0, 3));
      ld_base     = 4'($urandom);
      ld_valid    = $urandom_range(0, 1);
      ld_data     = 12'($urandom);
      ld_last     = $urandom_range(0, 3) == 0;
      cycle();
      n_vec++;
      if ({colr_valid, colr_out, act_bank, ld_ready, ld_done} !== {e_cv, e_co, mact, mload, mdone}) begin
        n_err++;
        $display("FAIL random cyc%0d got=%h exp=%h", i, {colr_valid, colr_out, act_bank, ld_ready, ld_done}, {e_cv, e_co, mact, mload, mdone});
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_wrap();
    test_bank_switch();
    test_sel_rules();
    test_ld_handshake();
    test_blank();
    test_random();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
